// File: rtl/sdram_model_mp.sv
// sdram_model_mp: cycle-level SDRAM controller model; ports clk/reset in, busy out, refresh_allowed in, per-port req in/ack out toggles, wr/addr/din/be in, dout out
module sdram_model_mp #(
  parameter int NPORTS   = 3,
  parameter int AW       = 24,
  parameter int MEM_LOG2 = 24,
  parameter int CL       = 2,
  parameter int RR       = 0,
  parameter int STARTUP  = 15,
  parameter int REFI     = 780,
  parameter int TRFC     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 busy,
  input  logic                 refresh_allowed,
  input  logic [NPORTS-1:0]    req,
  output logic [NPORTS-1:0]    ack,
  input  logic [NPORTS-1:0]    wr,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*16-1:0] din,
  input  logic [NPORTS*2-1:0]  be,
  output logic [NPORTS*16-1:0] dout
);
  localparam int PW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  typedef enum logic [2:0] {INIT, IDLE, ACT, CAS, REFRESH} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic rpend_q, rpend_d, busy_q, busy_d;
  logic [PW-1:0] ptr_q, ptr_d, gnt_q, sel;
  logic [NPORTS-1:0] ack_q, pend;
  logic [NPORTS*16-1:0] dout_q;
  logic wr_q, rq_q, any, accept, done;
  logic [MEM_LOG2-1:0] idx_q;
  logic [15:0] din_q;
  logic [1:0] be_q;
  logic [15:0] mem [2**MEM_LOG2];
  int start;
  assign pend  = req ^ ack_q;
  assign start = RR != 0 ? int'(ptr_q) + 1 : 0;
  assign busy  = busy_q;
  assign ack   = ack_q;
  assign dout  = dout_q;
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = 0; i < NPORTS; i++)
      if (!any && pend[PW'((start + i) % NPORTS)]) begin
        any = 1'b1;
        sel = PW'((start + i) % NPORTS);
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= 16'(STARTUP);
      rcnt_q  <= 16'(REFI);
      rpend_q <= 1'b0;
      busy_q  <= 1'b1;
      ptr_q   <= PW'(NPORTS - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      rpend_q <= rpend_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    rpend_d = rpend_q;
    ptr_d   = ptr_q;
    if (state_q != INIT && REFI != 0) begin
      if (rcnt_q == '0) rpend_d = 1'b1;
      else rcnt_d = rcnt_q - 16'd1;
    end
    case (state_q)
      INIT: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) state_d = IDLE;
      end
      IDLE: begin
        if (rpend_q && refresh_allowed) begin
          state_d = REFRESH;
          cnt_d   = 16'(TRFC);
        end else if (any) state_d = ACT;
      end
      ACT: begin
        state_d = CAS;
        cnt_d   = 16'(CL - 1);
      end
      CAS: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          ptr_d   = gnt_q;
        end
      end
      REFRESH: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) begin
          state_d = IDLE;
          rpend_d = 1'b0;
          rcnt_d  = 16'(REFI);
        end
      end
      default: state_d = INIT;
    endcase
  end
  always_comb begin
    busy_d = state_d != IDLE;
    accept = state_q == IDLE && state_d == ACT;
    done   = state_q == CAS && cnt_q == '0;
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      gnt_q <= sel;
      rq_q  <= req[sel];
      wr_q  <= wr[sel];
      idx_q <= addr[int'(sel)*AW +: MEM_LOG2];
      din_q <= din[int'(sel)*16 +: 16];
      be_q  <= be[int'(sel)*2 +: 2];
    end
    if (reset) begin
      ack_q  <= '0;
      dout_q <= '0;
    end else if (done) begin
      ack_q[gnt_q] <= rq_q;
      if (!wr_q) dout_q[int'(gnt_q)*16 +: 16] <= mem[idx_q];
    end
  end
  always_ff @(posedge clk)
    if (!reset && done && wr_q) begin
      if (be_q[0]) mem[idx_q][7:0] <= din_q[7:0];
      if (be_q[1]) mem[idx_q][15:8] <= din_q[15:8];
    end
endmodule

// File: tb/tb_sdram_model_mp.sv
// tb_sdram_model_mp: directed self-checking bench for sdram_model_mp (fixed/CL2/refresh instance and RR/CL3 instance)
module tb_sdram_model_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset [2], ra [2], busy [2];
  logic [2:0] req [2], ack [2], wr [2];
  logic [71:0] addr [2];
  logic [47:0] din [2], dout [2];
  logic [5:0] be [2];
  int checks = 0, errors = 0;
  sdram_model_mp #(.NPORTS(3), .AW(24), .MEM_LOG2(10), .CL(2), .RR(0), .STARTUP(15), .REFI(20), .TRFC(6)) dut_a (
    .clk(clk), .reset(reset[0]), .busy(busy[0]), .refresh_allowed(ra[0]), .req(req[0]), .ack(ack[0]),
    .wr(wr[0]), .addr(addr[0]), .din(din[0]), .be(be[0]), .dout(dout[0]));
  sdram_model_mp #(.NPORTS(3), .AW(24), .MEM_LOG2(10), .CL(3), .RR(1), .STARTUP(15), .REFI(0), .TRFC(6)) dut_b (
    .clk(clk), .reset(reset[1]), .busy(busy[1]), .refresh_allowed(ra[1]), .req(req[1]), .ack(ack[1]),
    .wr(wr[1]), .addr(addr[1]), .din(din[1]), .be(be[1]), .dout(dout[1]));
  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endfunction
  task automatic do_reset(input int d);
    int n;
    @(negedge clk);
    reset[d] = 1'b1;
    req[d] = '0;
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy[d]), 1);
    chk("rst_ack", 32'(ack[d]), 0);
    chk("rst_dout", 32'(dout[d]), 0);
    @(negedge clk);
    reset[d] = 1'b0;
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busy[d] !== 1'b1) break;
      n++;
    end
    chk("startup_cycles", n, 15);
    chk("post_startup_ack", 32'(ack[d]), 0);
  endtask
  task automatic acc(input int d, input int p, input logic w, input logic [23:0] a,
                     input logic [15:0] data, input logic [1:0] b, output int lat);
    @(negedge clk);
    wr[d][p] = w;
    addr[d][p*24 +: 24] = a;
    din[d][p*16 +: 16] = data;
    be[d][p*2 +: 2] = b;
    req[d][p] = ~req[d][p];
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack[d][p] === req[d][p]) begin
        lat = n - 1;
        break;
      end
    end
  endtask
  task automatic order_test(input int d, output logic [15:0] ord);
    logic [2:0] pa;
    int k;
    bit re;
    ord = '1;
    k = 0;
    re = 1'b0;
    @(negedge clk);
    pa = ack[d];
    for (int p = 0; p < 3; p++) begin
      wr[d][p] = 1'b0;
      addr[d][p*24 +: 24] = 24'(p);
    end
    req[d] = ~req[d];
    for (int n = 0; n < 80 && k < 4; n++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 3; p++)
        if (ack[d][p] !== pa[p] && k < 4) begin
          ord[k*4 +: 4] = 4'(p);
          k++;
        end
      pa = ack[d];
      if (!re && ack[d][0] === req[d][0]) begin
        re = 1'b1;
        req[d][0] = ~req[d][0];
      end
    end
  endtask
  initial begin
    int lat, n;
    logic [15:0] ord;
    logic [31:0] bp;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1;
      ra[d] = 1'b0;
      req[d] = '0;
      wr[d] = '0;
      addr[d] = '0;
      din[d] = '0;
      be[d] = '0;
    end
    repeat (2) @(posedge clk);
    do_reset(0);
    do_reset(1);
    acc(0, 1, 1'b1, 24'h123, 16'h1234, 2'b11, lat);
    chk("wr_full_lat", lat, 3);
    acc(0, 1, 1'b1, 24'h123, 16'hA55A, 2'b01, lat);
    chk("wr_lo_lat", lat, 3);
    acc(0, 1, 1'b0, 24'h123, 16'h0, 2'b00, lat);
    chk("rd_lat", lat, 3);
    chk("rd_lo_byte", 32'(dout[0][31:16]), 32'h125A);
    chk("dout0_held", 32'(dout[0][15:0]), 0);
    acc(0, 1, 1'b1, 24'h123, 16'hFFFF, 2'b00, lat);
    chk("be0_lat", lat, 3);
    acc(0, 1, 1'b0, 24'h123, 16'h0, 2'b00, lat);
    chk("be0_data", 32'(dout[0][31:16]), 32'h125A);
    order_test(0, ord);
    chk("order_fixed", 32'(ord), 32'h2100);
    order_test(1, ord);
    chk("order_rr", 32'(ord), 32'h0210);
    for (int i = 0; i < 3; i++) begin
      acc(0, 0, 1'b1, 24'h200 + 24'(i), 16'h5000 + 16'(i), 2'b11, lat);
      chk("held_refresh_lat", lat, 3);
    end
    n = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (busy[0] !== 1'b0) n++;
    end
    chk("no_refresh_busy", n, 0);
    @(negedge clk);
    ra[0] = 1'b1;
    wr[0][1] = 1'b0;
    addr[0][47:24] = 24'h123;
    req[0][1] = ~req[0][1];
    bp = '0;
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      bp[i-1] = busy[0];
      if (ack[0][1] === req[0][1]) begin
        n = i;
        break;
      end
    end
    chk("refresh_then_ack", n, 11);
    chk("refresh_busy_pattern", bp, 32'h3BF);
    chk("refresh_read_data", 32'(dout[0][31:16]), 32'h125A);
    ra[0] = 1'b0;
    acc(0, 0, 1'b1, 24'h10, 16'h1111, 2'b11, lat);
    chk("pre_cas_wr_lat", lat, 3);
    @(negedge clk);
    wr[0][0] = 1'b1;
    addr[0][23:0] = 24'h10;
    din[0][15:0] = 16'h2222;
    be[0][1:0] = 2'b11;
    req[0][0] = ~req[0][0];
    @(posedge clk);
    @(posedge clk);
    do_reset(0);
    acc(0, 0, 1'b0, 24'h10, 16'h0, 2'b00, lat);
    chk("after_reset_rd_lat", lat, 3);
    chk("cas_reset_mem", 32'(dout[0][15:0]), 32'h1111);
    acc(1, 2, 1'b1, 24'h005, 16'h0F0F, 2'b11, lat);
    chk("cl3_wr_lat", lat, 4);
    acc(1, 2, 1'b1, 24'h405, 16'hBEEF, 2'b11, lat);
    chk("cl3_alias_wr_lat", lat, 4);
    acc(1, 2, 1'b0, 24'h005, 16'h0, 2'b00, lat);
    chk("cl3_rd_lat", lat, 4);
    chk("alias_data", 32'(dout[1][47:32]), 32'hBEEF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
